// File: rtl/rr_mux_reg.sv
// rr_mux_reg: registered N-channel mux with explicit select
// or round-robin arbitration over valid/ready producers.
module rr_mux_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_src,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic            load;
  logic            hit;
  logic [SELW-1:0] gidx;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] nptr;
  logic [WIDTH-1:0] gdata;

  assign load = !out_valid | out_ready;
  assign nptr = (gidx == SELW'(CHANNELS - 1)) ? '0 : gidx + 1'b1;

  // Pick the granted channel: explicit index, or first requester at/after ptr
  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          hit  = 1'b1;
          gidx = SELW'(i);
        end
      end
    end else begin
      // wrapped segment first, then the segment from ptr overrides it
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (in_valid[i] && SELW'(i) < ptr) begin
          hit  = 1'b1;
          gidx = SELW'(i);
        end
      end
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (in_valid[i] && SELW'(i) >= ptr) begin
          hit  = 1'b1;
          gidx = SELW'(i);
        end
      end
    end
  end

  // Route granted data and raise the one-hot accept
  always_comb begin
    gdata    = '0;
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gidx == SELW'(i)) begin
        gdata = in_data[i*WIDTH +: WIDTH];
      end
      in_ready[i] = load & hit & (gidx == SELW'(i));
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (hit) begin
        out_valid <= 1'b1;
        out_data  <= gdata;
        out_src   <= gidx;
        if (mode) begin
          ptr <= nptr;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: directed and random stimulus for rr_mux_reg,
// scored against a queue-based model of the arbiter.
module tb_rr_mux_reg;
  localparam int W  = 8;
  localparam int CH = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH*W-1:0] in_data = '0;
  logic [CH-1:0] in_valid = '0;
  logic [CH-1:0] in_ready;
  logic          mode = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_src;
  logic          out_valid;
  logic          out_ready = 1'b0;

  rr_mux_reg #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel),
    .out_data(out_data), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    int           s;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   mptr  = 0;
  bit   mov   = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit vbit(logic [CH-1:0] v, int c);
    return ((v >> c) & 3'b001) != 3'b000;
  endfunction

  // Reference: which channel wins, ignoring output back-pressure
  function automatic int model_grant(logic [CH-1:0] v, bit m,
                                     int s);
    if (!m) begin
      if (s < CH && vbit(v, s)) return s;
      return -1;
    end
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (mptr + k) % CH;
      if (vbit(v, c)) return c;
    end
    return -1;
  endfunction

  function automatic logic [CH*W-1:0] pack(logic [W-1:0] a,
                                           logic [W-1:0] b,
                                           logic [W-1:0] c);
    return {c, b, a};
  endfunction

  // One cycle of stimulus: drive, check accept, update model
  task automatic drive(logic [CH-1:0] v, logic [CH*W-1:0] d,
                       bit m, logic [SW-1:0] s, bit ordy,
                       string name);
    int   g;
    bit   ld;
    exp_t e;
    @(posedge clk);
    #2;
    in_valid  = v;
    in_data   = d;
    mode      = m;
    sel       = s;
    out_ready = ordy;
    ld = !mov || ordy;
    g  = ld ? model_grant(v, m, int'(s)) : -1;
    #1;
    chk({name, " in_ready"}, 32'(in_ready),
        (g >= 0) ? 32'(1 << g) : 32'd0);
    if (g >= 0) begin
      e.d = W'(d >> (g * W));
      e.s = g;
      q.push_back(e);
      mov = 1;
      if (m) mptr = (g + 1) % CH;
    end else if (ld) begin
      mov = 0;
    end
  endtask

  // Monitor: every consumed output must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected output: got %0h expected none",
                 out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_src", 32'(out_src), 32'(e.s));
      end
    end
  end

  initial begin
    logic [CH*W-1:0] dd;
    @(posedge clk);
    #3;
    rst = 1'b0;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_src", 32'(out_src), 32'd0);

    // explicit select
    dd = pack(8'hAA, 8'hBB, 8'hC3);
    drive(3'b111, dd, 0, 2'd2, 1, "sel2");
    chk("sel2 onehot", 32'(in_ready), 32'b100);
    drive(3'b111, dd, 0, 2'd3, 1, "sel3");
    chk("sel3 onehot", 32'(in_ready), 32'd0);
    chk("sel2 data", 32'(out_data), 32'hC3);
    chk("sel2 src", 32'(out_src), 32'd2);
    drive(3'b000, dd, 0, 2'd3, 1, "idle");
    chk("sel3 drop", 32'(out_valid), 32'd0);

    // round-robin fairness and wrap: 0,1,2,0
    dd = pack(8'h01, 8'h02, 8'h03);
    drive(3'b111, dd, 1, 2'd0, 1, "rr0");
    chk("rr0 onehot", 32'(in_ready), 32'b001);
    drive(3'b111, dd, 1, 2'd0, 1, "rr1");
    chk("rr1 onehot", 32'(in_ready), 32'b010);
    chk("rr1 valid", 32'(out_valid), 32'd1);
    drive(3'b111, dd, 1, 2'd0, 1, "rr2");
    chk("rr2 onehot", 32'(in_ready), 32'b100);
    drive(3'b111, dd, 1, 2'd0, 1, "rr3");
    chk("rr3 wrap", 32'(in_ready), 32'b001);
    chk("rr3 valid", 32'(out_valid), 32'd1);

    // skip: ptr=1, only channel 0 requests
    drive(3'b001, dd, 1, 2'd0, 1, "skip");
    chk("skip onehot", 32'(in_ready), 32'b001);
    drive(3'b111, dd, 1, 2'd0, 1, "after skip");
    chk("after skip ptr", 32'(in_ready), 32'b010);

    // back-pressure: ptr=2, load 8'h11 from channel 0
    drive(3'b001, pack(8'h11, 8'h00, 8'h00), 1, 2'd0, 1, "bp load");
    chk("bp load onehot", 32'(in_ready), 32'b001);
    dd = pack(8'h22, 8'h33, 8'h44);
    for (int i = 0; i < 4; i++) begin
      drive(3'b111, dd, 1, 2'd0, 0, "stall");
      chk("stall data", 32'(out_data), 32'h11);
      chk("stall valid", 32'(out_valid), 32'd1);
    end
    drive(3'b111, dd, 1, 2'd0, 1, "unstall");
    chk("unstall onehot", 32'(in_ready), 32'b010);

    // mode switch: ptr=2 survives two explicit transfers
    drive(3'b111, dd, 0, 2'd0, 1, "msw0");
    chk("no bubble valid", 32'(out_valid), 32'd1);
    chk("no bubble data", 32'(out_data), 32'h33);
    drive(3'b111, dd, 0, 2'd0, 1, "msw1");
    drive(3'b111, dd, 1, 2'd0, 1, "msw rr");
    chk("msw rr onehot", 32'(in_ready), 32'b100);

    // reset mid-stream with 8'h5A held
    drive(3'b001, pack(8'h5A, 8'h00, 8'h00), 0, 2'd0, 1, "5a");
    drive(3'b000, '0, 0, 2'd0, 0, "5a hold");
    chk("5a held", 32'(out_data), 32'h5A);
    rst      = 1'b1;
    in_valid = '0;
    #1;
    chk("mid rst valid", 32'(out_valid), 32'd0);
    chk("mid rst data", 32'(out_data), 32'd0);
    chk("mid rst src", 32'(out_src), 32'd0);
    q.delete();
    mptr = 0;
    mov  = 0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    drive(3'b111, pack(8'h61, 8'h62, 8'h63), 1, 2'd0, 1, "post rst");
    chk("post rst onehot", 32'(in_ready), 32'b001);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(CH'($urandom_range(0, 7)), CH*W'($urandom),
            1'($urandom_range(0, 1)), SW'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, "rand");
    end

    // drain
    for (int i = 0; i < 3; i++) begin
      drive(3'b000, '0, 0, 2'd0, 1, "drain");
    end
    chk("queue empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
